// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter: write-port controller for a 2**AW x DW dual-port RAM.
// Shares the single synchronous write port (active-low we) between requesters
// A and B with round-robin priority, and provides a sequenced bulk clear that
// writes CLR_VAL to every location, one per cycle. The read port is passed
// through to the RAM.
//
// Optional build macro: RAM_RD_FWD_EN
//   defined   : rd_data forwards the in-flight write (including clear writes)
//   undefined : rd_data = mem_dataOut
//
// Ports:
//   ck, rst              clock (rising edge), asynchronous active-high reset
//   clr_start/clr_busy   bulk clear request (sampled in IDLE) / clear running
//   wa_*, wb_*           requester A/B valid/ready write handshakes
//   rd_adr/rd_data       read address / read data (combinational)
//   mem_dataIn, mem_adr_a, mem_we   registered RAM write-side signals
//   mem_adr_b, mem_dataOut          RAM read address / RAM read data
module ram_wr_arbiter #(
    parameter int unsigned   AW      = 7,
    parameter int unsigned   DW      = 8,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          wa_valid,
    input  logic [AW-1:0] wa_adr,
    input  logic [DW-1:0] wa_data,
    output logic          wa_ready,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_adr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_ready,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] mem_dataIn,
    output logic [AW-1:0] mem_adr_a,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr_b,
    input  logic [DW-1:0] mem_dataOut
);

    localparam logic [AW-1:0] LAST_ADR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ptr;        // 0: A owns priority, 1: B owns priority
    logic          ptr_nxt;
    logic [AW-1:0] cnt;        // next clear address
    logic [AW-1:0] cnt_nxt;
    logic          grant_a;
    logic          grant_b;
    logic          we_nxt;
    logic [AW-1:0] adr_nxt;
    logic [DW-1:0] data_nxt;

    // Grant decode: only in IDLE with no clear request; pointer breaks ties.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE && !clr_start) begin
            grant_a = wa_valid && (!wb_valid || !ptr);
            grant_b = wb_valid && (!wa_valid ||  ptr);
        end
    end

    assign wa_ready = grant_a;
    assign wb_ready = grant_b;

    // State register.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a clear runs until the last address has been issued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST_ADR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the RAM write port, counter and pointer.
    always_comb begin
        we_nxt   = 1'b1;
        adr_nxt  = mem_adr_a;
        data_nxt = mem_dataIn;
        cnt_nxt  = cnt;
        ptr_nxt  = ptr;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    cnt_nxt = '0;
                end else if (grant_a) begin
                    we_nxt   = 1'b0;
                    adr_nxt  = wa_adr;
                    data_nxt = wa_data;
                    ptr_nxt  = 1'b1;   // pointer goes to the requester that lost
                end else if (grant_b) begin
                    we_nxt   = 1'b0;
                    adr_nxt  = wb_adr;
                    data_nxt = wb_data;
                    ptr_nxt  = 1'b0;
                end
            end
            CLEAR: begin
                we_nxt   = 1'b0;
                adr_nxt  = cnt;
                data_nxt = CLR_VAL;
                cnt_nxt  = cnt + AW'(1);   // wraps to 0 after the last address
            end
            default: ;
        endcase
    end

    // Registered RAM write port, clear counter, pointer and busy flag.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b1;
            mem_adr_a  <= '0;
            mem_dataIn <= '0;
            cnt        <= '0;
            ptr        <= 1'b0;
            clr_busy   <= 1'b0;
        end else begin
            mem_we     <= we_nxt;
            mem_adr_a  <= adr_nxt;
            mem_dataIn <= data_nxt;
            cnt        <= cnt_nxt;
            ptr        <= ptr_nxt;
            clr_busy   <= (state_nxt == CLEAR);
        end
    end

    assign mem_adr_b = rd_adr;

`ifdef RAM_RD_FWD_EN
    // Forward the write that the RAM commits on the next edge.
    assign rd_data = (!mem_we && rd_adr == mem_adr_a) ? mem_dataIn : mem_dataOut;
`else
    assign rd_data = mem_dataOut;
`endif

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Testbench for ram_wr_arbiter: RAM model, table of arbitration vectors,
// directed clear/reset/forwarding sequences and a randomized run, all checked
// against a transaction-level reference model.
module tb_ram_wr_arbiter;

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 128;
    localparam logic [DW-1:0] CLR_VAL = 8'h00;

    logic          ck = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          clr_busy;
    logic          wa_valid;
    logic [AW-1:0] wa_adr;
    logic [DW-1:0] wa_data;
    logic          wa_ready;
    logic          wb_valid;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_data;
    logic          wb_ready;
    logic [AW-1:0] rd_adr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] mem_dataIn;
    logic [AW-1:0] mem_adr_a;
    logic          mem_we;
    logic [AW-1:0] mem_adr_b;
    logic [DW-1:0] mem_dataOut;
    logic          ram_init;

    int checks = 0;
    int errors = 0;

    ram_wr_arbiter #(.AW(AW), .DW(DW), .CLR_VAL(CLR_VAL)) dut (
        .ck(ck), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
        .wa_valid(wa_valid), .wa_adr(wa_adr), .wa_data(wa_data), .wa_ready(wa_ready),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data), .wb_ready(wb_ready),
        .rd_adr(rd_adr), .rd_data(rd_data),
        .mem_dataIn(mem_dataIn), .mem_adr_a(mem_adr_a), .mem_we(mem_we),
        .mem_adr_b(mem_adr_b), .mem_dataOut(mem_dataOut)
    );

    always #5 ck = ~ck;

    // RAM: synchronous write with active-low enable, asynchronous read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge ck) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i) | 8'h80;
        end else if (!mem_we) begin
            ram[mem_adr_a] <= mem_dataIn;
        end
    end
    assign mem_dataOut = ram[mem_adr_b];

    // Reference model: committed memory, the write in flight, clear progress.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_ptr;       // 0: A has priority
    int            m_left;      // clear cycles still to run, 0 when idle
    int            m_cnt;       // next address a clear writes
    bit            m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_data;
    bit            last_ga;
    bit            last_gb;

    typedef struct {
        bit            va;
        bit            vb;
        bit            ea;
        bit            eb;
        bit            we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 1'b0;
        m_left = 0;
        m_cnt  = 0;
        m_we   = 1'b1;
        m_adr  = '0;
        m_data = '0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (ram[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL mem[%0d]: got %0h expected %0h", i, ram[i], ref_mem[i]);
            end
        end
    endtask

    // One clock: check everything observable against the model, then advance it.
    task automatic run_cycle();
        bit            ea;
        bit            eb;
        logic [DW-1:0] erd;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (m_left == 0 && !clr_start) begin
            if (wa_valid && wb_valid) begin
                ea = (m_ptr == 1'b0);
                eb = (m_ptr == 1'b1);
            end else begin
                ea = wa_valid;
                eb = wb_valid;
            end
        end
`ifdef RAM_RD_FWD_EN
        erd = (!m_we && rd_adr == m_adr) ? m_data : ref_mem[rd_adr];
`else
        erd = ref_mem[rd_adr];
`endif
        check("wa_ready", wa_ready, ea);
        check("wb_ready", wb_ready, eb);
        check("clr_busy", clr_busy, m_left != 0);
        check("mem_we", mem_we, m_we);
        check("mem_adr_a", mem_adr_a, m_adr);
        check("mem_dataIn", mem_dataIn, m_data);
        check("mem_adr_b", mem_adr_b, rd_adr);
        check("rd_data", rd_data, erd);
        @(posedge ck);
        if (!m_we) ref_mem[m_adr] = m_data;
        if (m_left != 0) begin
            m_we   = 1'b0;
            m_adr  = AW'(m_cnt);
            m_data = CLR_VAL;
            m_cnt  = (m_cnt + 1) % DEPTH;
            m_left--;
        end else if (ea || eb) begin
            m_we   = 1'b0;
            m_adr  = ea ? wa_adr : wb_adr;
            m_data = ea ? wa_data : wb_data;
            m_ptr  = ea;
        end else begin
            m_we = 1'b1;
            if (clr_start) begin
                m_left = DEPTH;
                m_cnt  = 0;
            end
        end
        last_ga = ea;
        last_gb = eb;
        #1;
    endtask

    initial begin
        bit a_pend;
        bit b_pend;

        // ptr starts at B here: the first directed write is granted to A.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'h11};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'h22};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 8'h11};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'h22};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 8'h22};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'h22};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 8'h11};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'h11};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'h22};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd2, 8'h22};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 8'h11};

        rst = 1'b1; ram_init = 1'b1; clr_start = 1'b0;
        wa_valid = 1'b0; wa_adr = '0; wa_data = '0;
        wb_valid = 1'b0; wb_adr = '0; wb_data = '0;
        rd_adr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i) | 8'h80;
        model_reset();
        @(posedge ck); #1; ram_init = 1'b0;
        @(posedge ck); #1; rst = 1'b0;

        check("rst_we", mem_we, 1'b1);
        check("rst_adr", mem_adr_a, 0);
        check("rst_data", mem_dataIn, 0);
        check("rst_busy", clr_busy, 1'b0);

        // Single write from A, latency to RAM commit.
        wa_valid = 1'b1; wa_adr = 7'd5; wa_data = 8'hA5; rd_adr = 7'd5;
        #1; check("a5_ready", wa_ready, 1'b1);
        run_cycle();
        check("a5_we", mem_we, 1'b0);
        check("a5_adr", mem_adr_a, 5);
        check("a5_data", mem_dataIn, 8'hA5);
        wa_valid = 1'b0;
        run_cycle();
        check("a5_we_done", mem_we, 1'b1);
        check("a5_rd", rd_data, 8'hA5);

        // Arbitration vectors.
        wa_adr = 7'd1; wa_data = 8'h11; wb_adr = 7'd2; wb_data = 8'h22;
        foreach (vecs[i]) begin
            wa_valid = vecs[i].va;
            wb_valid = vecs[i].vb;
            #1;
            check("vec_wa_ready", wa_ready, vecs[i].ea);
            check("vec_wb_ready", wb_ready, vecs[i].eb);
            run_cycle();
            check("vec_we", mem_we, vecs[i].we);
            check("vec_adr", mem_adr_a, vecs[i].adr);
            check("vec_data", mem_dataIn, vecs[i].dat);
        end
        wa_valid = 1'b0; wb_valid = 1'b0;
        run_cycle();

        // Reset in the middle of a clear, with address 40 in flight.
        clr_start = 1'b1;
        run_cycle();
        clr_start = 1'b0;
        for (int k = 0; k < 41; k++) run_cycle();
        check("abort_adr", mem_adr_a, 40);
        check("abort_we_before", mem_we, 1'b0);
        #1; rst = 1'b1; #1;
        check("abort_we", mem_we, 1'b1);
        check("abort_busy", clr_busy, 1'b0);
        model_reset();
        @(posedge ck); #1; rst = 1'b0;
        check_mem();
        check("abort_mem39", ram[39], CLR_VAL);
        check("abort_mem40", ram[40], 8'hA8);

        // Full clear with A pending and a second clr_start mid-clear.
        wa_valid = 1'b1; wa_adr = 7'd7; wa_data = 8'h77; clr_start = 1'b1;
        #1; check("clr_blocks_a", wa_ready, 1'b0);
        run_cycle();
        clr_start = 1'b0;
        check("clr_busy_on", clr_busy, 1'b1);
        check("clr_entry_we", mem_we, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            clr_start = (k == 60);
            run_cycle();
            check("clr_adr", mem_adr_a, k);
            check("clr_we", mem_we, 1'b0);
            check("clr_val", mem_dataIn, CLR_VAL);
        end
        clr_start = 1'b0;
        check("clr_busy_off", clr_busy, 1'b0);
        #1; check("pend_ready", wa_ready, 1'b1);
        run_cycle();
        check("pend_adr", mem_adr_a, 7);
        check("pend_data", mem_dataIn, 8'h77);
        wa_valid = 1'b0;
        run_cycle();
        check("post_clr_busy", clr_busy, 1'b0);
        check_mem();

        // Read of an address whose write was accepted on the previous edge.
        wa_valid = 1'b1; wa_adr = 7'd9; wa_data = 8'h3C; rd_adr = '0;
        run_cycle();
        wa_valid = 1'b0; rd_adr = 7'd9;
        #1;
`ifdef RAM_RD_FWD_EN
        check("fwd_rd", rd_data, 8'h3C);
`else
        check("fwd_rd", rd_data, CLR_VAL);
`endif
        run_cycle();
        check("fwd_rd_late", rd_data, 8'h3C);

        // Randomized traffic; requesters hold their request until accepted.
        a_pend = 1'b0; b_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1;
                wa_adr = 7'($urandom_range(0, 15));
                wa_data = 8'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend = 1'b1;
                wb_adr = 7'($urandom_range(0, 15));
                wb_data = 8'($urandom);
            end
            wa_valid  = a_pend;
            wb_valid  = b_pend;
            clr_start = ($urandom_range(0, 299) == 0);
            rd_adr    = ($urandom_range(0, 3) == 0) ? m_adr : 7'($urandom_range(0, 15));
            run_cycle();
            if (last_ga) a_pend = 1'b0;
            if (last_gb) b_pend = 1'b0;
        end
        wa_valid = 1'b0; wb_valid = 1'b0; clr_start = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) run_cycle();
        check_mem();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
